// File: rtl/prog_loader_if.sv
// Byte stream port feeding the program loader: the source drives data/valid, the loader drives ready.
interface prog_loader_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length/payload/checksum frame, writes the payload to
// program memory from address 0 and holds the cpu in reset until the checksum matches.
module prog_loader #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int RESET_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   prog_loader_if.slave      bus,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam int HOLD_W = $clog2(RESET_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_CSUM,
      S_HOLD,
      S_RUN,
      S_ERR
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] w_lenNext;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] w_countNext;
   logic [DATA_W-1:0] r_sum;
   logic [DATA_W-1:0] w_sumNext;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_holdNext;
   logic              r_memWe;
   logic              w_memWeNext;
   logic [ADDR_W-1:0] r_memAddr;
   logic [ADDR_W-1:0] w_memAddrNext;
   logic [DATA_W-1:0] r_memWdata;
   logic [DATA_W-1:0] w_memWdataNext;
   logic              r_cpuReset;
   logic              w_cpuResetNext;
   logic              w_inReady;
   logic              w_fire;

   assign w_inReady = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign w_fire    = bus.in_valid && w_inReady;

   assign bus.in_ready = w_inReady;
   assign mem_we       = r_memWe;
   assign mem_addr     = r_memAddr;
   assign mem_wdata    = r_memWdata;
   assign cpu_reset    = r_cpuReset;
   assign done         = (r_state == S_RUN);
   assign error        = (r_state == S_ERR);

   // A length byte of zero means a full 2**ADDR_W image; r_len - 1 then wraps to the last address.
   always_comb begin
      w_stateNext    = r_state;
      w_lenNext      = r_len;
      w_countNext    = r_count;
      w_sumNext      = r_sum;
      w_holdNext     = r_hold;
      w_memWeNext    = 1'b0;
      w_memAddrNext  = r_memAddr;
      w_memWdataNext = r_memWdata;

      case (r_state)
         S_LEN: begin
            if (w_fire) begin
               w_lenNext   = ADDR_W'(bus.in_data);
               w_countNext = '0;
               w_sumNext   = '0;
               w_stateNext = S_DATA;
            end
         end
         S_DATA: begin
            if (w_fire) begin
               w_memWeNext    = 1'b1;
               w_memAddrNext  = r_count;
               w_memWdataNext = bus.in_data;
               w_sumNext      = r_sum + bus.in_data;
               w_countNext    = r_count + ADDR_ONE;
               if (r_count == r_len - ADDR_ONE) begin
                  w_stateNext = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (w_fire) begin
               if (bus.in_data == r_sum) begin
                  w_holdNext  = HOLD_INIT;
                  w_stateNext = S_HOLD;
               end else begin
                  w_stateNext = S_ERR;
               end
            end
         end
         S_HOLD: begin
            if (r_hold <= HOLD_ONE) begin
               w_holdNext  = '0;
               w_stateNext = S_RUN;
            end else begin
               w_holdNext = r_hold - HOLD_ONE;
            end
         end
         S_RUN, S_ERR: begin
            if (reload) begin
               w_stateNext = S_LEN;
            end
         end
         default: begin
            w_stateNext = S_LEN;
         end
      endcase

      w_cpuResetNext = (w_stateNext != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_LEN;
         r_len      <= '0;
         r_count    <= '0;
         r_sum      <= '0;
         r_hold     <= '0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_cpuReset <= 1'b1;
      end else begin
         r_state    <= w_stateNext;
         r_len      <= w_lenNext;
         r_count    <= w_countNext;
         r_sum      <= w_sumNext;
         r_hold     <= w_holdNext;
         r_memWe    <= w_memWeNext;
         r_memAddr  <= w_memAddrNext;
         r_memWdata <= w_memWdataNext;
         r_cpuReset <= w_cpuResetNext;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a capture memory records every write pulse, and a tiny
// instruction model executes the loaded image once the cpu is released.
module tb_prog_loader;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       reload;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       done;
   logic       error;

   logic [7:0] tbMem [256];
   int         wrCount   = 0;
   int         testsRun  = 0;
   int         failCount = 0;

   prog_loader_if #(.DATA_W(8)) bus ();

   prog_loader #(
      .ADDR_W(8),
      .DATA_W(8),
      .RESET_HOLD(HOLD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .reload(reload),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_reset(cpu_reset),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         tbMem[mem_addr] <= mem_wdata;
         wrCount         <= wrCount + 1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired, simulation still running");
      $fatal(1, "[TB] watchdog");
   end

   // Returns #1 after the edge that completed the handshake.
   task automatic sendByte(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      if (!ok) begin
         testsRun++; failCount++;
         $display("[TB] FAIL handshake byte=%02h in_ready=%b want 1", d, bus.in_ready);
      end
   endtask

   task automatic waitDone();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (done === 1'b1) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) begin
         testsRun++; failCount++;
         $display("[TB] FAIL wait_done done=%b error=%b want done=1", done, error);
      end
   endtask

   task automatic pulseReload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      reload       = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      testsRun++;
      if ({cpu_reset, bus.in_ready, mem_we, done, error} !== 5'b11000) begin
         failCount++;
         $display("[TB] FAIL reset_flags {cpu_reset,in_ready,mem_we,done,error} got %b want 11000",
                  {cpu_reset, bus.in_ready, mem_we, done, error});
      end
      testsRun++;
      if ({mem_addr, mem_wdata} !== 16'h0000) begin
         failCount++;
         $display("[TB] FAIL reset_bus addr/wdata got %04h want 0000", {mem_addr, mem_wdata});
      end
   endtask

   task automatic test_basic_load();
      logic [7:0] pay [3];
      int w0;
      pay = '{8'hA1, 8'hB2, 8'hC3};
      w0  = wrCount;
      sendByte(8'h03);
      for (int i = 0; i < 3; i++) begin
         sendByte(pay[i]);
         testsRun++;
         if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'(i), pay[i]}) begin
            failCount++;
            $display("[TB] FAIL basic_write%0d we/addr/data got %b/%02h/%02h want 1/%02h/%02h",
                     i, mem_we, mem_addr, mem_wdata, i, pay[i]);
         end
      end
      sendByte(8'h16);
      testsRun++;
      if ({mem_we, bus.in_ready, cpu_reset, done} !== 4'b0010) begin
         failCount++;
         $display("[TB] FAIL basic_hold {we,ready,cpu_reset,done} got %b want 0010",
                  {mem_we, bus.in_ready, cpu_reset, done});
      end
      for (int j = 1; j < HOLD; j++) begin
         @(posedge clk);
         #1;
         testsRun++;
         if (cpu_reset !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL basic_hold_cycle%0d cpu_reset got %b want 1", j, cpu_reset);
         end
      end
      @(posedge clk);
      #1;
      testsRun++;
      if ({cpu_reset, done} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL basic_release {cpu_reset,done} got %b want 01", {cpu_reset, done});
      end
      testsRun++;
      if ((wrCount - w0) != 3 || {tbMem[0], tbMem[1], tbMem[2]} !== 24'hA1B2C3) begin
         failCount++;
         $display("[TB] FAIL basic_mem writes=%0d mem=%02h%02h%02h want 3 A1B2C3",
                  wrCount - w0, tbMem[0], tbMem[1], tbMem[2]);
      end
      // in_valid while running must be ignored
      w0 = wrCount;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      testsRun++;
      if ({bus.in_ready, done, cpu_reset} !== 3'b010 || wrCount != w0) begin
         failCount++;
         $display("[TB] FAIL run_ignores_valid {ready,done,cpu_reset}=%b writes=%0d want 010 0",
                  {bus.in_ready, done, cpu_reset}, wrCount - w0);
      end
   endtask

   task automatic test_reload_from_run();
      pulseReload();
      testsRun++;
      if ({cpu_reset, bus.in_ready, done, error} !== 4'b1100) begin
         failCount++;
         $display("[TB] FAIL reload_run {cpu_reset,ready,done,error} got %b want 1100",
                  {cpu_reset, bus.in_ready, done, error});
      end
   endtask

   task automatic test_bad_checksum();
      int w0;
      w0 = wrCount;
      sendByte(8'h02);
      sendByte(8'h10);
      sendByte(8'h20);
      sendByte(8'h31);
      testsRun++;
      if ({error, cpu_reset, bus.in_ready, done} !== 4'b1100) begin
         failCount++;
         $display("[TB] FAIL bad_csum {error,cpu_reset,ready,done} got %b want 1100",
                  {error, cpu_reset, bus.in_ready, done});
      end
      repeat (HOLD + 2) @(posedge clk);
      #1;
      testsRun++;
      if ({error, cpu_reset} !== 2'b11 || (wrCount - w0) != 2) begin
         failCount++;
         $display("[TB] FAIL bad_csum_park {error,cpu_reset}=%b writes=%0d want 11 2",
                  {error, cpu_reset}, wrCount - w0);
      end
      pulseReload();
      testsRun++;
      if ({error, cpu_reset, bus.in_ready} !== 3'b011) begin
         failCount++;
         $display("[TB] FAIL bad_csum_reload {error,cpu_reset,ready} got %b want 011",
                  {error, cpu_reset, bus.in_ready});
      end
   endtask

   task automatic test_full_size();
      int w0;
      int bad;
      w0 = wrCount;
      sendByte(8'h00);
      for (int i = 0; i < 256; i++) sendByte(8'(i));
      testsRun++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'hFF, 8'hFF}) begin
         failCount++;
         $display("[TB] FAIL full_last we/addr/data got %b/%02h/%02h want 1/FF/FF",
                  mem_we, mem_addr, mem_wdata);
      end
      sendByte(8'h80);
      waitDone();
      bad = 0;
      for (int i = 0; i < 256; i++) if (tbMem[i] !== 8'(i)) bad++;
      testsRun++;
      if (done !== 1'b1 || (wrCount - w0) != 256 || bad != 0) begin
         failCount++;
         $display("[TB] FAIL full_image done=%b writes=%0d bad=%0d want 1 256 0",
                  done, wrCount - w0, bad);
      end
      pulseReload();
   endtask

   task automatic test_gaps();
      logic [7:0] frame [7];
      int w0;
      frame = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
      w0 = wrCount;
      for (int i = 0; i < 7; i++) begin
         bus.in_data = 8'($urandom);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         sendByte(frame[i]);
      end
      waitDone();
      testsRun++;
      if ((wrCount - w0) != 5 || {tbMem[0], tbMem[1], tbMem[2], tbMem[3], tbMem[4]} !== 40'h1122334455) begin
         failCount++;
         $display("[TB] FAIL gaps writes=%0d mem=%02h%02h%02h%02h%02h want 5 1122334455",
                  wrCount - w0, tbMem[0], tbMem[1], tbMem[2], tbMem[3], tbMem[4]);
      end
      testsRun++;
      if ({done, cpu_reset} !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL gaps_run {done,cpu_reset} got %b want 10", {done, cpu_reset});
      end
      pulseReload();
   endtask

   task automatic test_reset_midload();
      sendByte(8'h04);
      sendByte(8'h01);
      sendByte(8'h02);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      testsRun++;
      if ({cpu_reset, bus.in_ready, mem_we, done, error} !== 5'b11000 || mem_addr !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL midload_reset {cpu_reset,ready,we,done,error}=%b addr=%02h want 11000 00",
                  {cpu_reset, bus.in_ready, mem_we, done, error}, mem_addr);
      end
      sendByte(8'h02);
      sendByte(8'hAA);
      sendByte(8'hBB);
      sendByte(8'h65);
      waitDone();
      testsRun++;
      if ({done, cpu_reset} !== 2'b10 || {tbMem[0], tbMem[1]} !== 16'hAABB) begin
         failCount++;
         $display("[TB] FAIL midload_reload {done,cpu_reset}=%b mem=%02h%02h want 10 AABB",
                  {done, cpu_reset}, tbMem[0], tbMem[1]);
      end
      pulseReload();
   endtask

   // Image: LDI r0,5 / LDI r1,7 / ADD r1,r0 / HLT
   task automatic test_cpu_program();
      logic [7:0] image [8];
      logic [7:0] regs [4];
      logic [7:0] ir;
      int pc;
      image = '{8'h06, 8'h10, 8'h05, 8'h11, 8'h07, 8'h24, 8'hF0, 8'h41};
      for (int i = 0; i < 8; i++) sendByte(image[i]);
      waitDone();
      regs = '{8'h00, 8'h00, 8'h00, 8'h00};
      ir   = 8'h00;
      pc   = 0;
      for (int step = 0; step < 16 && ir != 8'hF0; step++) begin
         ir = tbMem[pc[7:0]];
         pc++;
         case (ir[7:4])
            4'h1: begin
               regs[ir[1:0]] = tbMem[pc[7:0]];
               pc++;
            end
            4'h2: regs[ir[3:2]] = regs[ir[3:2]] + regs[ir[1:0]];
            default: ;
         endcase
      end
      testsRun++;
      if (ir !== 8'hF0 || regs[0] !== 8'h05 || regs[1] !== 8'h0C || cpu_reset !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL cpu_program ir=%02h r0=%02h r1=%02h cpu_reset=%b want F0 05 0C 0",
                  ir, regs[0], regs[1], cpu_reset);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      test_reset();
      test_basic_load();
      test_reload_from_run();
      test_bad_checksum();
      test_full_size();
      test_gaps();
      test_reset_midload();
      test_cpu_program();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
